// File: rtl/iob_native_sram_resp_pkg.sv
// Shared types and helpers for the IOb native SRAM responder.
//   state_e : responder FSM encoding (IDLE=0, WAIT=1, RESP=2)
//   req_w   : packed request width {valid, addr, wdata, wstrb}
//   resp_w  : packed response width {rdata, ready}
package iob_native_sram_resp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int unsigned resp_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_sram_be.sv
// Single-port SRAM with per-byte write enable and registered read.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset (read register only; array is not reset)
//   en_i    : access strobe
//   be_i    : byte enables; non-zero means write, zero means read
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data; cleared by a write access
module iob_sram_be #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // A write response carries zero data, so the read register is cleared on writes.
  always_comb begin
    rdata_d = rdata_q;
    if (en_i) begin
      rdata_d = (|be_i) ? '0 : mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_native_sram_resp.sv
// IOb native bus responder serving requests from an internal byte-enabled SRAM.
// Every accepted request gets exactly one single-cycle ready pulse.
//   clk         : clock
//   rst         : asynchronous active-high reset
//   req         : {valid, addr[ADDR_W-1:0], wdata[DATA_W-1:0], wstrb[DATA_W/8-1:0]}
//   resp        : {rdata[DATA_W-1:0], ready}
//   wait_cycles : extra response cycles per request, sampled at accept
// Build option: define IOB_NATIVE_SRAM_RESP_WAIT_EN to enable programmable wait states;
// otherwise wait_cycles is ignored and latency is fixed at one cycle.
module iob_native_sram_resp
  import iob_native_sram_resp_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_ADDR_W = 10,
  parameter int unsigned WAIT_W     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [req_w(ADDR_W, DATA_W)-1:0]  req,
  output logic [resp_w(DATA_W)-1:0]         resp,
  input  logic [WAIT_W-1:0]                 wait_cycles
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned ReqW  = req_w(ADDR_W, DATA_W);

  // Request field extraction
  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [StrbW-1:0]      wstrb;
  logic [MEM_ADDR_W-1:0] mem_addr;

  assign valid    = req[ReqW-1];
  assign addr     = req[ReqW-2 -: ADDR_W];
  assign wdata    = req[StrbW +: DATA_W];
  assign wstrb    = req[StrbW-1:0];
  // Upper address bits alias; byte offset is ignored.
  assign mem_addr = addr[MEM_ADDR_W+1:2];

  logic unused_addr;
  assign unused_addr = ^{addr[ADDR_W-1:MEM_ADDR_W+2], addr[1:0]};

  state_e state_q, state_d;
  logic   accept;
  logic   ready;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] sram_rdata;

`ifdef IOB_NATIVE_SRAM_RESP_WAIT_EN
  logic [WAIT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_wait;
  assign unused_wait = ^wait_cycles;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
`ifdef IOB_NATIVE_SRAM_RESP_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef IOB_NATIVE_SRAM_RESP_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic; IDLE and RESP accept with identical rules.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
`ifdef IOB_NATIVE_SRAM_RESP_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle, StResp: begin
        if (valid) begin
          accept = 1'b1;
`ifdef IOB_NATIVE_SRAM_RESP_WAIT_EN
          cnt_d   = wait_cycles;
          state_d = (wait_cycles != '0) ? StWait : StResp;
`else
          state_d = StResp;
`endif
        end else begin
          state_d = StIdle;
        end
      end
`ifdef IOB_NATIVE_SRAM_RESP_WAIT_EN
      // Bus is not sampled here; the response completes even if valid drops.
      StWait: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q <= WAIT_W'(1)) begin
          state_d = StResp;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state_q == StResp);
    rdata = ready ? sram_rdata : '0;
  end

  assign resp = {rdata, ready};

  // The SRAM access completes on the accept edge, so read-after-write has no hazard.
  iob_sram_be #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_sram (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (accept),
    .be_i    (wstrb),
    .addr_i  (mem_addr),
    .wdata_i (wdata),
    .rdata_o (sram_rdata)
  );

endmodule

// File: tb/tb_iob_native_sram_resp.sv
module tb_iob_native_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [68:0] req;
  logic [32:0] resp;
  logic [3:0]  wait_cycles;

  int checks = 0;
  int errors = 0;

`ifdef IOB_NATIVE_SRAM_RESP_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  iob_native_sram_resp dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .resp        (resp),
    .wait_cycles (wait_cycles)
  );

  always #5 clk = ~clk;

  // Drives one request held until ready; returns cycles from accept edge to ready and rdata.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output int lat, output logic [31:0] rd);
    @(negedge clk);
    req = {1'b1, a, wd, ws};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp[0] && lat < 50);
    rd  = resp[32:1];
    req = '0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (resp !== 33'd0) begin
      errors++;
      $display("FAIL reset_resp: got %h want 0", resp);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (resp !== 33'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h want 0", resp);
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] rd;
    issue(32'h10, 32'hDEADBEEF, 4'hF, lat, rd);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL wr_latency: got %0d want 1", lat); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rd); end
    // ready must be a single-cycle pulse
    @(negedge clk);
    checks++;
    if (resp[0] !== 1'b0) begin errors++; $display("FAIL ready_pulse: got %b want 0", resp[0]); end
    issue(32'h10, 32'h0, 4'h0, lat, rd);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL rd_latency: got %0d want 1", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_enable();
    int lat;
    logic [31:0] rd;
    issue(32'h20, 32'h11223344, 4'hF, lat, rd);
    issue(32'h20, 32'h0000AA00, 4'h2, lat, rd);
    issue(32'h20, 32'h0, 4'h0, lat, rd);
    checks++;
    if (rd !== 32'h1122AA44) begin errors++; $display("FAIL byte_en: got %h want 1122aa44", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0 writes the eight words back to back, pass 1 reads them back to back
      int n = 0;
      int cyc = 0;
      int first = -1;
      int last = -1;
      @(negedge clk);
      req = {1'b1, 32'h0, 32'hC0DE0000, (pass == 0) ? 4'hF : 4'h0};
      while (n < 8 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (resp[0]) begin
          exp = (pass == 0) ? 32'h0 : (32'hC0DE0000 | (n * 32'h0101));
          checks++;
          if (resp[32:1] !== exp) begin
            errors++;
            $display("FAIL b2b_data p%0d n%0d: got %h want %h", pass, n, resp[32:1], exp);
          end
          if (first < 0) first = cyc;
          last = cyc;
          n++;
          if (n < 8)
            req = {1'b1, 32'(n * 4), 32'hC0DE0000 | (n * 32'h0101),
                   (pass == 0) ? 4'hF : 4'h0};
          else
            req = '0;
        end
      end
      req = '0;
      checks++;
      if (n !== 8) begin errors++; $display("FAIL b2b_count p%0d: got %0d want 8", pass, n); end
      checks++;
      if (last - first !== 7) begin
        errors++;
        $display("FAIL b2b_span p%0d: got %0d want 7", pass, last - first);
      end
    end
  endtask

  task automatic test_wait_states();
    int lat;
    int exp_lat;
    logic [31:0] rd;
    wait_cycles = 4'd3;
    @(negedge clk);
    req = {1'b1, 32'h20, 32'h0, 4'h0};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) wait_cycles = 4'd0;  // must not shorten the request in flight
    end while (!resp[0] && lat < 50);
    rd  = resp[32:1];
    req = '0;
    exp_lat = WaitEn ? 4 : 1;
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL wait3_latency: got %0d want %0d", lat, exp_lat);
    end
    checks++;
    if (rd !== 32'h1122AA44) begin errors++; $display("FAIL wait3_data: got %h want 1122aa44", rd); end
    wait_cycles = 4'd2;
    issue(32'h20, 32'h0, 4'h0, lat, rd);
    exp_lat = WaitEn ? 3 : 1;
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL wait2_latency: got %0d want %0d", lat, exp_lat);
    end
    @(negedge clk);
    checks++;
    if (resp[0] !== 1'b0) begin errors++; $display("FAIL wait_pulse: got %b want 0", resp[0]); end
    wait_cycles = 4'd0;
  endtask

  task automatic test_reset_mid_request();
    int lat;
    logic [31:0] rd;
    wait_cycles = 4'd5;
    @(negedge clk);
    req = {1'b1, 32'h40, 32'hCAFEF00D, 4'hF};
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (resp !== 33'd0) begin errors++; $display("FAIL rst_async: got %h want 0", resp); end
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    wait_cycles = 4'd0;
    @(negedge clk);
    checks++;
    if (resp !== 33'd0) begin errors++; $display("FAIL rst_idle: got %h want 0", resp); end
    issue(32'h40, 32'h0, 4'h0, lat, rd);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL rst_rd_latency: got %0d want 1", lat); end
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_rd_data: got %h want cafef00d", rd); end
  endtask

  task automatic test_aliasing();
    int lat;
    logic [31:0] rd;
    issue(32'h0000_1004, 32'h5A5AA5A5, 4'hF, lat, rd);
    issue(32'h0000_0006, 32'h0, 4'h0, lat, rd);
    checks++;
    if (rd !== 32'h5A5AA5A5) begin errors++; $display("FAIL alias: got %h want 5a5aa5a5", rd); end
  endtask

  initial begin
    rst         = 1'b1;
    req         = '0;
    wait_cycles = 4'd0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_wait_states();
    test_reset_mid_request();
    test_aliasing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
